// File: rtl/mux_arb_pkg.sv
// Shared constants and helpers for the four-requester round-robin arbiter.
package mux_arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
      return NUM_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority search: first set bit of req at or above ptr (mod 4),
// optionally skipping one excluded index.
module rr_pick4
   import mux_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   input  logic               excl_en,
   input  logic [SEL_W-1:0]   excl,
   output logic               valid,
   output logic [SEL_W-1:0]   idx
);

   logic [SEL_W-1:0] cand;

   always_comb begin
      valid = 1'b0;
      idx   = ptr;
      cand  = ptr;
      for (int off = 0; off < NUM_REQ; off++) begin
         cand = ptr + SEL_W'(off);
         if (!valid && req[cand] && !(excl_en && (cand == excl))) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter with bounded hold time driving a shared 4:1 data path.
// req/gnt is level based: a requester keeps req high for as long as it wants the path.
module mux4_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic [DATA_W-1:0]  d0,
   input  logic [DATA_W-1:0]  d1,
   input  logic [DATA_W-1:0]  d2,
   input  logic [DATA_W-1:0]  d3,
   output logic [NUM_REQ-1:0] gnt,
   output logic               s1,
   output logic               s0,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_valid,
   output logic [0:0]         dbg_state
);

   localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

   logic [0:0]         state, nxt_state;
   logic [SEL_W-1:0]   sel, nxt_sel;
   logic [SEL_W-1:0]   ptr, nxt_ptr;
   logic [3:0]         hold_cnt, nxt_hold;
   logic [NUM_REQ-1:0] nxt_gnt;
   logic               nxt_valid;
   logic               pick_valid;
   logic [SEL_W-1:0]   pick_idx;
   logic               owner_req;
   logic               take_new;

   // While granting, the owner is excluded so a hold-limit rotation always moves on.
   rr_pick4 u_pick (
      .req     (req),
      .ptr     (ptr),
      .excl_en (state == GRANT),
      .excl    (sel),
      .valid   (pick_valid),
      .idx     (pick_idx)
   );

   assign owner_req = req[sel];

   always_comb begin
      nxt_state = state;
      nxt_gnt   = gnt;
      nxt_sel   = sel;
      nxt_valid = out_valid;
      nxt_ptr   = ptr;
      nxt_hold  = hold_cnt;
      take_new  = 1'b0;
      if (state == GRANT) begin
         if (!owner_req) begin
            if (pick_valid) begin
               take_new = 1'b1;
            end else begin
               nxt_state = IDLE;
               nxt_gnt   = '0;
               nxt_valid = 1'b0;
            end
         end else if ((hold_cnt == HOLD_LAST) && pick_valid) begin
            take_new = 1'b1;
         end else if (hold_cnt != HOLD_LAST) begin
            nxt_hold = hold_cnt + 4'd1;
         end
      end else begin
         take_new = pick_valid;
      end
      if (take_new) begin
         nxt_state = GRANT;
         nxt_gnt   = onehot(pick_idx);
         nxt_sel   = pick_idx;
         nxt_valid = 1'b1;
         nxt_ptr   = pick_idx + 2'd1;
         nxt_hold  = 4'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         gnt       <= '0;
         sel       <= '0;
         out_valid <= 1'b0;
         ptr       <= '0;
         hold_cnt  <= '0;
      end else begin
         state     <= nxt_state;
         gnt       <= nxt_gnt;
         sel       <= nxt_sel;
         out_valid <= nxt_valid;
         ptr       <= nxt_ptr;
         hold_cnt  <= nxt_hold;
      end
   end

   always_comb begin
      case (sel)
         2'd0:    out_data = d0;
         2'd1:    out_data = d1;
         2'd2:    out_data = d2;
         default: out_data = d3;
      endcase
   end

   assign s1        = sel[1];
   assign s0        = sel[0];
   assign dbg_state = state;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed vectors through a scoreboard queue,
// async reset checks, then a randomized fairness and one-hot phase.
module tb_mux4_rr_arbiter;

   localparam int DATA_W   = 8;
   localparam int MAX_HOLD = 4;
   localparam int MAX_WAIT = 3 * MAX_HOLD + 1;
   localparam logic [7:0] D0 = 8'h10;
   localparam logic [7:0] D1 = 8'hA5;
   localparam logic [7:0] D2 = 8'h3C;
   localparam logic [7:0] D3 = 8'hC3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [3:0]        req;
   logic [7:0]        d0, d1, d2, d3;
   logic [3:0]        gnt;
   logic              s1, s0;
   logic [7:0]        out_data;
   logic              out_valid;
   logic [0:0]        dbg_state;

   logic [14:0]       exp_q[$];
   int                vectors     = 0;
   int                miscompares = 0;
   bit                rnd_on      = 1'b0;
   int                wait_c[4];

   mux4_rr_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .d0        (d0),
      .d1        (d1),
      .d2        (d2),
      .d3        (d3),
      .gnt       (gnt),
      .s1        (s1),
      .s0        (s0),
      .out_data  (out_data),
      .out_valid (out_valid),
      .dbg_state (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   function automatic logic [7:0] lane(input logic [1:0] s);
      case (s)
         2'd0:    return D0;
         2'd1:    return D1;
         2'd2:    return D2;
         default: return D3;
      endcase
   endfunction

   // driver: req goes out on the falling edge, expectation is for the next rising edge
   task automatic apply(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s,
                        input logic v);
      @(negedge clk);
      req = r;
      exp_q.push_back({g, s, v, lane(s)});
   endtask

   task automatic check_zero(input string name);
      vectors++;
      if ({gnt, s1, s0, out_valid} !== 7'd0) begin
         miscompares++;
         $display("FAIL %s: got gnt=%b s1s0=%b%b vld=%b, exp all zero", name, gnt, s1, s0,
                  out_valid);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = 4'b0000;
      #1 check_zero("sync_rst");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // scoreboard monitor for directed vectors
   always @(posedge clk) begin
      logic [14:0] e;
      logic [14:0] a;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {gnt, s1, s0, out_valid, out_data};
         vectors++;
         if (a !== e) begin
            miscompares++;
            $display("FAIL dir_vec %0d: got gnt=%b sel=%b vld=%b data=%h, exp gnt=%b sel=%b vld=%b data=%h",
                     vectors, a[14:11], a[10:9], a[8], a[7:0], e[14:11], e[10:9], e[8], e[7:0]);
         end
      end
   end

   // random-phase property monitor
   always @(posedge clk) begin
      bit bad;
      #1;
      if (rnd_on) begin
         bad = 1'b0;
         vectors++;
         if ($countones(gnt) > 1) bad = 1'b1;
         if (out_valid !== (|gnt)) bad = 1'b1;
         if (out_valid && (gnt !== (4'b0001 << {s1, s0}))) bad = 1'b1;
         if (out_data !== lane({s1, s0})) bad = 1'b1;
         for (int i = 0; i < 4; i++) begin
            if (req[i] && !gnt[i]) wait_c[i]++;
            else wait_c[i] = 0;
            if (wait_c[i] > MAX_WAIT) bad = 1'b1;
         end
         if (bad) begin
            miscompares++;
            $display("FAIL rnd_prop: got gnt=%b s1s0=%b%b vld=%b data=%h waits=%0d/%0d/%0d/%0d, exp one-hot, vld=|gnt, data=%h, waits<=%0d",
                     gnt, s1, s0, out_valid, out_data, wait_c[0], wait_c[1], wait_c[2],
                     wait_c[3], lane({s1, s0}), MAX_WAIT);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      req   = 4'b0000;
      d0 = D0; d1 = D1; d2 = D2; d3 = D3;
      #2 check_zero("por_rst");
      @(negedge clk);
      rst_n = 1'b1;

      // single requester held: granted after one cycle, kept indefinitely
      repeat (6) apply(4'b0010, 4'b0010, 2'd1, 1'b1);
      apply(4'b0000, 4'b0000, 2'd1, 1'b0);
      apply(4'b0000, 4'b0000, 2'd1, 1'b0);

      // all requesting: each owner exactly MAX_HOLD cycles, no idle gap
      do_reset();
      for (int i = 0; i < 20; i++)
         apply(4'b1111, 4'(1 << ((i / 4) % 4)), 2'((i / 4) % 4), 1'b1);
      apply(4'b0000, 4'b0000, 2'd0, 1'b0);

      // ptr=1: 3 wins, drop with only 0 pending wraps to 0, then a newcomer joins on drop
      apply(4'b1000, 4'b1000, 2'd3, 1'b1);
      apply(4'b0001, 4'b0001, 2'd0, 1'b1);
      apply(4'b1010, 4'b0010, 2'd1, 1'b1);
      apply(4'b0100, 4'b0100, 2'd2, 1'b1);
      apply(4'b0000, 4'b0000, 2'd2, 1'b0);

      // ptr=3: two requesters share by hold limit
      for (int i = 0; i < 9; i++)
         apply(4'b0101, (i >= 4 && i < 8) ? 4'b0100 : 4'b0001,
               (i >= 4 && i < 8) ? 2'd2 : 2'd0, 1'b1);
      apply(4'b0000, 4'b0000, 2'd0, 1'b0);

      // ptr=1: search order favours 3 over 0
      apply(4'b1001, 4'b1000, 2'd3, 1'b1);
      apply(4'b0001, 4'b0001, 2'd0, 1'b1);

      // asynchronous reset between edges, then ptr restarts at 0
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      req   = 4'b0000;
      #1 check_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      apply(4'b0011, 4'b0001, 2'd0, 1'b1);
      apply(4'b1000, 4'b1000, 2'd3, 1'b1);
      apply(4'b0000, 4'b0000, 2'd3, 1'b0);
      apply(4'b1000, 4'b1000, 2'd3, 1'b1);
      apply(4'b0000, 4'b0000, 2'd3, 1'b0);
      @(negedge clk);

      // randomized requesters: each holds req until served, then may release
      for (int i = 0; i < 4; i++) wait_c[i] = 0;
      rnd_on = 1'b1;
      repeat (2000) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (req[i]) begin
               if (gnt[i] && ($urandom_range(0, 3) == 0)) req[i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               req[i] = 1'b1;
            end
         end
      end
      @(negedge clk);
      rnd_on = 1'b0;
      req    = 4'b0000;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
